// File: rtl/m_mux_rr.sv
// N:1 valid/ready mux with round-robin or explicit-select arbitration; 1-cycle latency into one output register.
// Backpressure: a held word blocks all o_ready until downstream accepts; a drain and a reload can share a cycle.
module m_mux_rr #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4,
  parameter int SEL_MODE = 0,
  localparam int SELW    = $clog2(CHANNELS)
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [CHANNELS*WIDTH-1:0] i_data,
  input  logic [CHANNELS-1:0]       i_valid,
  output logic [CHANNELS-1:0]       o_ready,
  input  logic [SELW-1:0]           i_sel,
  output logic [WIDTH-1:0]          o_data,
  output logic                      o_valid,
  output logic [SELW-1:0]           o_chan,
  input  logic                      i_ready
);

  logic [SELW-1:0]     ptr;
  logic [SELW-1:0]     gnt;
  logic [SELW-1:0]     ptr_nxt;
  logic [SELW-1:0]     idx_s;
  logic [CHANNELS-1:0] elig;
  logic [WIDTH-1:0]    ch_dat [CHANNELS];
  logic                found;
  logic                load_slot;
  logic                xfer;
  int                  idx;

  always_comb begin
    for (int k = 0; k < CHANNELS; k++) begin
      ch_dat[k] = i_data[k*WIDTH +: WIDTH];
    end
  end

  // In select mode only one channel can ever be eligible, so the same search serves both modes.
  always_comb begin
    elig = '0;
    if (SEL_MODE == 0) begin
      elig = i_valid;
    end else if (int'(i_sel) < CHANNELS) begin
      elig[i_sel] = i_valid[i_sel];
    end
  end

  always_comb begin
    found   = 1'b0;
    gnt     = '0;
    ptr_nxt = ptr;
    idx     = 0;
    idx_s   = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      idx = int'(ptr) + i;
      if (idx >= CHANNELS) idx = idx - CHANNELS;
      idx_s = SELW'(idx);
      if (!found && elig[idx_s]) begin
        found   = 1'b1;
        gnt     = idx_s;
        ptr_nxt = (idx == CHANNELS - 1) ? '0 : SELW'(idx + 1);
      end
    end
  end

  assign load_slot = !o_valid || i_ready;
  assign xfer      = i_rst_n && found && load_slot;

  always_comb begin
    o_ready = '0;
    if (xfer) o_ready[gnt] = 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_data  <= '0;
      o_valid <= 1'b0;
      o_chan  <= '0;
      ptr     <= '0;
    end else begin
      if (xfer) begin
        o_data  <= ch_dat[gnt];
        o_chan  <= gnt;
        o_valid <= 1'b1;
        if (SEL_MODE == 0) ptr <= ptr_nxt;
      end else if (i_ready) begin
        o_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_m_mux_rr.sv
// Scoreboarded bench for m_mux_rr: one round-robin instance and one explicit-select instance.
module tb_m_mux_rr;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [63:0] data = '0;

  logic [3:0]  valid0 = '0, ready_o0;
  logic        ready0 = 1'b0, o_valid0;
  logic [15:0] o_data0;
  logic [1:0]  o_chan0;

  logic [3:0]  valid1 = '0, ready_o1;
  logic        ready1 = 1'b0, o_valid1;
  logic [15:0] o_data1;
  logic [1:0]  o_chan1;
  logic [1:0]  sel = '0;

  int checks = 0;
  int failures = 0;

  logic [17:0] q0[$];
  logic [17:0] q1[$];

  always #5 clk = ~clk;

  m_mux_rr #(.WIDTH(16), .CHANNELS(4), .SEL_MODE(0)) d0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(data), .i_valid(valid0), .o_ready(ready_o0),
    .i_sel(sel), .o_data(o_data0), .o_valid(o_valid0), .o_chan(o_chan0), .i_ready(ready0));

  m_mux_rr #(.WIDTH(16), .CHANNELS(4), .SEL_MODE(1)) d1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(data), .i_valid(valid1), .o_ready(ready_o1),
    .i_sel(sel), .o_data(o_data1), .o_valid(o_valid1), .o_chan(o_chan1), .i_ready(ready1));

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] pk(input logic [15:0] d3, input logic [15:0] d2,
                                     input logic [15:0] d1, input logic [15:0] d0v);
    return {d3, d2, d1, d0v};
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Monitors: every word accepted downstream must match the head of its queue.
  always @(negedge clk) begin
    if (rst_n && o_valid0 && ready0) begin
      if (q0.size() == 0) begin
        checks++; failures++;
        $display("FAIL mon0_unexpected chan=%0d data=%h expected=none", o_chan0, o_data0);
      end else begin
        check("mon0_word", {46'd0, o_chan0, o_data0}, {46'd0, q0.pop_front()});
      end
    end
    if (rst_n && o_valid1 && ready1) begin
      if (q1.size() == 0) begin
        checks++; failures++;
        $display("FAIL mon1_unexpected chan=%0d data=%h expected=none", o_chan1, o_data1);
      end else begin
        check("mon1_word", {46'd0, o_chan1, o_data1}, {46'd0, q1.pop_front()});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog_timeout actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int          fair_ch [6] = '{0, 1, 2, 3, 0, 1};
    logic [3:0]  exp_rdy;
    logic [1:0]  ch;

    // Reset state, asserted asynchronously before any clock edge.
    #1 rst_n = 1'b0;
    #2;
    check("rst_o_valid", 64'(o_valid0), 64'd0);
    check("rst_o_data", 64'(o_data0), 64'd0);
    check("rst_o_chan", 64'(o_chan0), 64'd0);
    check("rst_ptr", 64'(d0.ptr), 64'd0);
    valid0 = 4'b1111;
    valid1 = 4'b1111;
    #1;
    check("rst_o_ready0", 64'(ready_o0), 64'd0);
    check("rst_o_ready1", 64'(ready_o1), 64'd0);
    next_cycle();
    check("rst_o_valid_clocked", 64'(o_valid0), 64'd0);
    valid1 = 4'b0000;

    // Single requester on channel 2.
    rst_n  = 1'b1;
    data   = pk(16'h0, 16'hBEEF, 16'h0, 16'h0);
    valid0 = 4'b0100;
    ready0 = 1'b1;
    q0.push_back({2'd2, 16'hBEEF});
    @(negedge clk);
    check("single_o_ready", 64'(ready_o0), 64'b0100);
    next_cycle();
    valid0 = 4'b0000;
    @(negedge clk);
    check("single_o_valid", 64'(o_valid0), 64'd1);
    check("single_o_chan", 64'(o_chan0), 64'd2);
    check("single_ptr", 64'(d0.ptr), 64'd3);
    next_cycle();

    // Wrap-around from ptr=3; also the drained register holds its last word.
    data   = pk(16'h0, 16'h0, 16'h00A1, 16'h00A0);
    valid0 = 4'b0011;
    q0.push_back({2'd0, 16'h00A0});
    @(negedge clk);
    check("drain_o_valid", 64'(o_valid0), 64'd0);
    check("drain_o_data_hold", 64'(o_data0), 64'hBEEF);
    check("wrap_o_ready", 64'(ready_o0), 64'b0001);
    next_cycle();
    valid0 = 4'b0000;
    @(negedge clk);
    check("wrap_ptr", 64'(d0.ptr), 64'd1);
    check("wrap_o_chan", 64'(o_chan0), 64'd0);
    next_cycle();

    // Bring ptr to 0 via channel 3, then full-rate fairness sweep.
    data   = pk(16'h1003, 16'h1002, 16'h1001, 16'h1000);
    valid0 = 4'b1000;
    q0.push_back({2'd3, 16'h1003});
    @(negedge clk);
    check("ch3_o_ready", 64'(ready_o0), 64'b1000);
    next_cycle();
    valid0 = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      ch = 2'(fair_ch[i]);
      exp_rdy = 4'b0001 << ch;
      q0.push_back({ch, 16'h1000 | 16'(ch)});
      @(negedge clk);
      check("fair_o_ready", 64'(ready_o0), 64'(exp_rdy));
      if (i > 0) check("fair_o_valid", 64'(o_valid0), 64'd1);
      next_cycle();
    end

    // Backpressure while holding channel 1's word.
    ready0 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_o_ready", 64'(ready_o0), 64'd0);
      check("bp_o_data", 64'(o_data0), 64'h1001);
      check("bp_o_valid", 64'(o_valid0), 64'd1);
      next_cycle();
    end
    ready0 = 1'b1;
    q0.push_back({2'd2, 16'h1002});
    @(negedge clk);
    check("bp_release_o_ready", 64'(ready_o0), 64'b0100);
    next_cycle();
    valid0 = 4'b0000;
    @(negedge clk);
    check("bp_release_o_chan", 64'(o_chan0), 64'd2);
    next_cycle();
    @(negedge clk);
    check("idle_o_valid", 64'(o_valid0), 64'd0);
    check("idle_o_data_hold", 64'(o_data0), 64'h1002);

    // Async reset with a held word (never accepted, so nothing queued).
    next_cycle();
    ready0 = 1'b0;
    valid0 = 4'b0001;
    next_cycle();
    valid0 = 4'b0000;
    @(negedge clk);
    check("pre_rst_o_valid", 64'(o_valid0), 64'd1);
    #2;
    rst_n  = 1'b0;
    valid0 = 4'b1100;
    #1;
    check("arst_o_valid", 64'(o_valid0), 64'd0);
    check("arst_o_data", 64'(o_data0), 64'd0);
    check("arst_o_ready", 64'(ready_o0), 64'd0);
    check("arst_ptr", 64'(d0.ptr), 64'd0);
    next_cycle();
    check("arst_hold_o_valid", 64'(o_valid0), 64'd0);
    rst_n  = 1'b1;
    ready0 = 1'b1;
    q0.push_back({2'd2, 16'h1002});
    @(negedge clk);
    check("post_rst_o_ready", 64'(ready_o0), 64'b0100);
    next_cycle();
    valid0 = 4'b0000;
    @(negedge clk);
    check("post_rst_o_chan", 64'(o_chan0), 64'd2);
    next_cycle();

    // Explicit select mode, with a select change mid-stream.
    sel    = 2'd3;
    valid1 = 4'b1001;
    ready1 = 1'b1;
    q1.push_back({2'd3, 16'h1003});
    @(negedge clk);
    check("sel3_o_ready", 64'(ready_o1), 64'b1000);
    next_cycle();
    sel = 2'd0;
    q1.push_back({2'd0, 16'h1000});
    @(negedge clk);
    check("sel0_o_ready", 64'(ready_o1), 64'b0001);
    next_cycle();
    sel    = 2'd3;
    valid1 = 4'b0001;
    @(negedge clk);
    check("sel_invalid_o_ready", 64'(ready_o1), 64'd0);
    check("sel_invalid_o_valid", 64'(o_valid1), 64'd1);
    next_cycle();
    @(negedge clk);
    check("sel_drain_o_valid", 64'(o_valid1), 64'd0);
    check("sel_drain_o_data", 64'(o_data1), 64'h1000);
    check("sel_ptr", 64'(d1.ptr), 64'd0);
    next_cycle();
    valid1 = 4'b0000;

    @(negedge clk);
    check("q0_empty", 64'(q0.size()), 64'd0);
    check("q1_empty", 64'(q1.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/m_mux_rr.md
M_MUX_RR -- requirements
Module: m_mux_rr

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, the data bits per channel, legal from 1 to 64.
REQ-002 The block SHALL have parameter CHANNELS, default 4, the number of input channels, legal from 2 to 8.
REQ-003 The block SHALL have parameter SEL_MODE, default 0; 0 = round-robin arbitration, 1 = explicit select via i_sel.
REQ-004 SELW SHALL equal clog2(CHANNELS).
REQ-005 The block SHALL have port i_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port i_rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-007 The block SHALL have port i_data, input, CHANNELS*WIDTH bits: channel k occupies bits [k*WIDTH +: WIDTH].
REQ-008 The block SHALL have port i_valid, input, CHANNELS bits: per-channel valid.
REQ-009 The block SHALL have port o_ready, output, CHANNELS bits: per-channel accept, combinational.
REQ-010 The block SHALL have port i_sel, input, SELW bits: the selected channel, used only when SEL_MODE=1.
REQ-011 The block SHALL have port o_data, output, WIDTH bits: registered output data.
REQ-012 The block SHALL have port o_valid, output, 1 bit: output register holds data.
REQ-013 The block SHALL have port o_chan, output, SELW bits: source channel of o_data.
REQ-014 The block SHALL have port i_ready, input, 1 bit: downstream accept.

Function
REQ-015 The block SHALL contain one output register stage (o_data, o_valid, o_chan) and a grant pointer ptr of SELW bits.
REQ-016 A load slot SHALL exist in a cycle when o_valid=0 or i_ready=1.
REQ-017 Eligibility in SEL_MODE=0: channel k SHALL be eligible when i_valid[k]=1.
REQ-018 Eligibility in SEL_MODE=1: only channel i_sel SHALL be eligible, and only when i_valid[i_sel]=1; i_sel>=CHANNELS SHALL make no channel eligible.
REQ-019 Round-robin grant SHALL go to the first eligible channel searching ptr, ptr+1, ..., wrapping modulo CHANNELS.
REQ-020 o_ready SHALL be one-hot or zero: o_ready[g]=1 only for the granted channel g, and only when a load slot exists; all others SHALL be 0.
REQ-021 A transfer SHALL occur on channel g when i_valid[g]=1 and o_ready[g]=1 at a rising edge.
REQ-022 On a transfer, the block SHALL set o_data to channel g data, o_chan to g, and o_valid to 1 in the next cycle (latency 1 cycle).
REQ-023 On a transfer in SEL_MODE=0, ptr SHALL become (g+1) mod CHANNELS.
REQ-024 ptr SHALL be unchanged when no transfer occurs and in SEL_MODE=1.
REQ-025 On output drain (o_valid=1, i_ready=1) with no new transfer, o_valid SHALL go to 0; o_data and o_chan SHALL hold their last value.
REQ-026 When drain and transfer occur in the same cycle, the new word SHALL load and o_valid SHALL stay 1, giving full throughput of 1 word per cycle.
REQ-027 Under backpressure (o_valid=1, i_ready=0), o_data, o_chan and o_valid SHALL hold stable and all o_ready SHALL be 0.
REQ-028 A requester whose i_valid stays high SHALL be granted within CHANNELS transfers in SEL_MODE=0 (starvation-free).
REQ-029 Changing i_sel mid-stream SHALL take effect on the next grant decision; no word SHALL be lost or duplicated.

Reset
REQ-030 While i_rst_n=0, the block SHALL hold o_valid=0, o_data=0, o_chan=0, ptr=0, and o_ready=0, asynchronously and regardless of the clock.
REQ-031 A reset asserted mid-operation SHALL discard any held word; after release, the first grant SHALL search from channel 0.
REQ-032 Operation SHALL resume at the first rising edge after i_rst_n deasserts.

Verification
REQ-033 Scenario, WIDTH=16, CHANNELS=4, SEL_MODE=0: after reset, assert only i_valid[2] with data 0xBEEF and i_ready=1 -> o_ready=4'b0100; next cycle o_data=0xBEEF, o_chan=2, o_valid=1; ptr=3.
REQ-034 Scenario, round-robin fairness: i_valid=4'b1111 held, i_ready=1, channel k data=0x1000+k -> o_chan sequence 0,1,2,3,0 on consecutive cycles, one word per cycle.
REQ-035 Scenario, backpressure: o_valid=1 holding 0x1001 and i_ready=0 for 3 cycles, i_valid=4'b1111 -> o_ready=0, o_data stays 0x1001; on i_ready=1, the next word is from channel 2.
REQ-036 Scenario, SEL_MODE=1: i_sel=3, i_valid=4'b1001 -> only o_ready[3]=1; with i_sel=3 and i_valid[3]=0 -> o_ready=0 and o_valid drops after drain.
REQ-037 Scenario, async reset: pull i_rst_n low between clock edges while o_valid=1 -> o_valid=0, o_data=0 immediately; after release with i_valid=4'b1100, the first grant is channel 2.
REQ-038 Scenario, wrap-around: ptr=3 and i_valid=4'b0011 -> channel 0 is granted, then ptr=1.
